axo_bus_arbiter: RTL and testbench

- Shares one external memory bus between the CPU's instruction-fetch port (prog_*) and its data port (mem_*).
- Sits between the RV32 core and the single-ported system memory/MMIO fabric.
- Arbitrates zero-latency when idle and holds ownership across wait states.
- Data port has fixed priority; a starvation counter guarantees fetch forward progress.

---
 rtl/axo_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_axo_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axo_bus_arbiter.sv
// Shares one memory bus between the instruction-fetch port and the data port.
// The data port has fixed priority, and a starvation counter lets a waiting fetch win after starve_limit data grants.
module axo_bus_arbiter #(
  parameter int unsigned starve_limit = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_re,
  input  logic [30:0] prog_addr,
  output logic        prog_ready,
  output logic [31:0] prog_data,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_asize,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_re,
  output logic        bus_we,
  output logic [1:0]  bus_asize,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PROG, OWN_DATA} owner_t;

  localparam logic [7:0] LIMIT = 8'(starve_limit);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  owner_t      sel;
  owner_t      active;
  logic        data_req;

  assign data_req  = mem_re | mem_we;
  assign prog_data = bus_rdata;
  assign mem_rdata = bus_rdata;
  assign busy      = (state_q == BUSY) && !rst;

  always_comb begin
    sel = OWN_NONE;
    if (prog_re && (cnt_q == LIMIT)) sel = OWN_PROG;
    else if (data_req)               sel = OWN_DATA;
    else if (prog_re)                sel = OWN_PROG;
  end

  // In BUSY, the owner dropping its request is an abort: the bus is released immediately.
  always_comb begin
    active = OWN_NONE;
    if (!rst) begin
      if (state_q == IDLE) begin
        active = sel;
      end else if ((owner_q == OWN_PROG && prog_re) || (owner_q == OWN_DATA && data_req)) begin
        active = owner_q;
      end
    end
  end

  always_comb begin
    bus_re     = 1'b0;
    bus_we     = 1'b0;
    bus_asize  = 2'd0;
    bus_addr   = 32'd0;
    bus_wdata  = 32'd0;
    prog_ready = 1'b0;
    mem_ready  = 1'b0;
    case (active)
      OWN_PROG: begin
        bus_re     = 1'b1;
        bus_asize  = 2'd2;
        bus_addr   = {prog_addr, 1'b0};
        prog_ready = bus_ready;
      end
      OWN_DATA: begin
        bus_we     = mem_we;
        bus_re     = mem_re & ~mem_we;
        bus_asize  = mem_asize;
        bus_addr   = mem_addr;
        bus_wdata  = mem_wdata;
        mem_ready  = bus_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (active != OWN_NONE && !bus_ready) begin
        state_d = BUSY;
        owner_d = active;
      end
    end else if (active == OWN_NONE || bus_ready) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
    end

    if (!prog_re) begin
      cnt_d = 8'd0;
    end else if (bus_ready && active == OWN_PROG) begin
      cnt_d = 8'd0;
    end else if (bus_ready && active == OWN_DATA && cnt_q < LIMIT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axo_bus_arbiter.sv
// Directed bench for axo_bus_arbiter: expected completions go into a scoreboard queue
// that a negedge monitor pops whenever prog_ready or mem_ready is seen.
module tb_axo_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        prog_re;
  logic [30:0] prog_addr;
  logic        prog_ready;
  logic [31:0] prog_data;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_asize;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_re;
  logic        bus_we;
  logic [1:0]  bus_asize;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        busy;

  typedef struct packed {
    logic        is_prog;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  axo_bus_arbiter #(.starve_limit(4)) dut (
    .clk(clk), .rst(rst),
    .prog_re(prog_re), .prog_addr(prog_addr), .prog_ready(prog_ready), .prog_data(prog_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_asize(mem_asize), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_re(bus_re), .bus_we(bus_we), .bus_asize(bus_asize), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic push(input logic p, input logic [31:0] d);
    exp_t e;
    e.is_prog = p;
    e.data    = d;
    sb_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (prog_ready || mem_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready prog_ready=%b mem_ready=%b required none", prog_ready, mem_ready);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_prog_ready", {31'b0, prog_ready}, {31'b0, mon_e.is_prog});
        chk("sb_mem_ready", {31'b0, mem_ready}, {31'b0, ~mon_e.is_prog});
        chk("sb_rdata", mon_e.is_prog ? prog_data : mem_rdata, mon_e.data);
        $display("txn %s rdata=%h", mon_e.is_prog ? "PROG" : "DATA", mon_e.is_prog ? prog_data : mem_rdata);
      end
    end
  end

  initial begin
    rst = 1'b1; prog_re = 1'b1; prog_addr = 31'h123; mem_re = 1'b0; mem_we = 1'b0;
    mem_asize = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0; bus_rdata = 32'd0; bus_ready = 1'b1;

    // reset forces the bus and handshakes low
    @(negedge clk);
    chk1("rst_bus_re", bus_re, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    nxt();
    rst = 1'b0; prog_re = 1'b0;
    nxt();

    // lone fetch, zero-latency
    prog_re = 1'b1; prog_addr = 31'h2000_0000; bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
    push(1'b1, 32'h1111_2222);
    @(negedge clk);
    chk("t1_bus_addr", bus_addr, 32'h4000_0000);
    chk("t1_bus_asize", {30'b0, bus_asize}, 32'd2);
    chk1("t1_bus_re", bus_re, 1'b1);
    chk1("t1_busy", busy, 1'b0);
    nxt();
    prog_re = 1'b0;

    // data write with two wait states
    mem_we = 1'b1; mem_asize = 2'd2; mem_addr = 32'hffff_ff04; mem_wdata = 32'hdead_beef;
    bus_ready = 1'b0; bus_rdata = 32'h5a5a_0001;
    @(negedge clk);
    chk1("t2_c1_bus_we", bus_we, 1'b1);
    chk("t2_c1_wdata", bus_wdata, 32'hdead_beef);
    chk1("t2_c1_busy", busy, 1'b0);
    nxt();
    @(negedge clk);
    chk1("t2_c2_busy", busy, 1'b1);
    chk1("t2_c2_bus_we", bus_we, 1'b1);
    chk("t2_c2_addr", bus_addr, 32'hffff_ff04);
    nxt();
    bus_ready = 1'b1;
    push(1'b0, 32'h5a5a_0001);
    @(negedge clk);
    chk1("t2_c3_busy", busy, 1'b1);
    nxt();
    mem_we = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    chk1("t2_idle_busy", busy, 1'b0);
    chk1("t2_idle_bus_we", bus_we, 1'b0);
    nxt();

    // starvation: four data grants, then the fetch wins
    prog_re = 1'b1; prog_addr = 31'h100; mem_re = 1'b1; mem_asize = 2'd1;
    mem_addr = 32'h8000_0010; bus_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_rdata = 32'hA000_0000 + 32'(i);
      push(i == 4, 32'hA000_0000 + 32'(i));
      @(negedge clk);
      chk("t3_bus_addr", bus_addr, (i == 4) ? 32'h0000_0200 : 32'h8000_0010);
      chk("t3_bus_asize", {30'b0, bus_asize}, (i == 4) ? 32'd2 : 32'd1);
      nxt();
    end
    bus_rdata = 32'hA000_0005;
    push(1'b0, 32'hA000_0005);
    @(negedge clk);
    chk("t3_after_clear_addr", bus_addr, 32'h8000_0010);
    nxt();
    mem_we = 1'b1; bus_rdata = 32'hA000_0006;
    push(1'b0, 32'hA000_0006);
    @(negedge clk);
    chk1("t3_rw_bus_we", bus_we, 1'b1);
    chk1("t3_rw_bus_re", bus_re, 1'b0);
    nxt();
    prog_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk1("t3_idle_bus_re", bus_re, 1'b0);
    nxt();

    // fetch owns the bus while a data request arrives
    prog_re = 1'b1; prog_addr = 31'h40; bus_ready = 1'b0;
    @(negedge clk);
    chk1("t4_c1_bus_re", bus_re, 1'b1);
    chk1("t4_c1_busy", busy, 1'b0);
    nxt();
    mem_we = 1'b1; mem_addr = 32'h0000_1000; mem_wdata = 32'h1234_5678; mem_asize = 2'd2;
    @(negedge clk);
    chk1("t4_c2_busy", busy, 1'b1);
    chk("t4_c2_addr", bus_addr, 32'h0000_0080);
    chk1("t4_c2_bus_we", bus_we, 1'b0);
    nxt();
    bus_ready = 1'b1; bus_rdata = 32'hC0DE_0001;
    push(1'b1, 32'hC0DE_0001);
    @(negedge clk);
    chk("t4_c3_addr", bus_addr, 32'h0000_0080);
    nxt();
    prog_re = 1'b0; bus_rdata = 32'hC0DE_0002;
    push(1'b0, 32'hC0DE_0002);
    @(negedge clk);
    chk1("t4_c4_busy", busy, 1'b0);
    chk1("t4_c4_bus_we", bus_we, 1'b1);
    chk("t4_c4_addr", bus_addr, 32'h0000_1000);
    chk("t4_c4_wdata", bus_wdata, 32'h1234_5678);
    nxt();
    mem_we = 1'b0; bus_ready = 1'b0;
    nxt();

    // saturate the counter, then reset must clear it
    prog_re = 1'b1; prog_addr = 31'h100; mem_re = 1'b1; mem_addr = 32'h0000_2000;
    mem_asize = 2'd0; bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_rdata = 32'hB000_0000 + 32'(i);
      push(1'b0, 32'hB000_0000 + 32'(i));
      nxt();
    end
    rst = 1'b1;
    @(negedge clk);
    chk1("t5_rst_bus_re", bus_re, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_addr", bus_addr, 32'd0);
    nxt();
    rst = 1'b0; bus_rdata = 32'hB000_0004;
    push(1'b0, 32'hB000_0004);
    @(negedge clk);
    chk("t5_post_rst_addr", bus_addr, 32'h0000_2000);
    nxt();
    prog_re = 1'b0; mem_re = 1'b0; bus_ready = 1'b0;
    nxt();

    // reset while a data write is in BUSY
    mem_we = 1'b1; mem_addr = 32'h0000_3000; mem_wdata = 32'h0000_0001; mem_asize = 2'd2;
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk1("t6_rst_bus_we", bus_we, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk1("t6_after_busy", busy, 1'b0);
    chk1("t6_after_bus_we", bus_we, 1'b1);
    nxt();
    bus_ready = 1'b1; bus_rdata = 32'hD000_0001;
    push(1'b0, 32'hD000_0001);
    @(negedge clk);
    chk1("t6_done_busy", busy, 1'b1);
    nxt();
    mem_we = 1'b0; bus_ready = 1'b0;
    nxt();

    // data owner aborts; the pending fetch is granted in the next IDLE cycle
    mem_re = 1'b1; mem_addr = 32'h0000_4000;
    @(negedge clk);
    chk1("t7_c1_bus_re", bus_re, 1'b1);
    nxt();
    mem_re = 1'b0; prog_re = 1'b1; prog_addr = 31'h300;
    @(negedge clk);
    chk1("t7_abort_bus_re", bus_re, 1'b0);
    chk("t7_abort_addr", bus_addr, 32'd0);
    chk1("t7_abort_busy", busy, 1'b1);
    nxt();
    bus_ready = 1'b1; bus_rdata = 32'hE000_0001;
    push(1'b1, 32'hE000_0001);
    @(negedge clk);
    chk1("t7_fetch_bus_re", bus_re, 1'b1);
    chk("t7_fetch_addr", bus_addr, 32'h0000_0600);
    chk1("t7_fetch_busy", busy, 1'b0);
    nxt();
    prog_re = 1'b0; bus_ready = 1'b0;
    nxt();
    nxt();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
